multiplier_taint_radix: RTL
===========================

Name: multiplier_taint_radix

Overview:
Parametrised successor to the 1-bit-taint sequential shift-add multiplier. It retires STEP multiplier bits per cycle, supports a runtime signed/unsigned mode, and has an explicit busy indicator. Its latency is constant and independent of the data, so the done/busy taint depends only on control taint. It sits beside the existing multiplier in taint-tracked datapaths, with one coarse taint bit per operand.

Parameters:
WIDTH, 32, operand width in bits (>=4)
STEP, 2, multiplier bits retired per compute cycle; WIDTH % STEP == 0 (elaboration error otherwise)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
start_t  input  1  taint of start
signed_mode  input  1  1 = two's-complement operands; latched at accept
signed_mode_t  input  1  taint of signed_mode
multiplier  input  WIDTH  operand A, latched at accept
multiplier_t  input  1  taint of A
multiplicand  input  WIDTH  operand B, latched at accept
multiplicand_t  input  1  taint of B
busy  output  1  high from the cycle after accept through the done cycle
busy_t  output  1  taint of busy
product  output  2*WIDTH  result; held until next accept
product_t  output  1  taint of product
productDone  output  1  one-cycle pulse when product becomes valid
productDone_t  output  1  taint of productDone

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE. busy, busy_t, product, product_t, productDone, productDone_t all 0. Counter and internal registers are cleared. Reset aborts any operation in progress, and nothing from that operation reaches the outputs.
- Constants: N = WIDTH/STEP.
- States:
  - IDLE: busy=0. Accept = start at an edge.
  - CALC: busy=1. Exactly N cycles. Cycle i adds (B * A digit i) << (i*STEP) into the running sum. The digit is STEP bits, LSB digit first.
  - DONE: busy=1 and productDone=1 for exactly one cycle; product is updated at entry. Next state is IDLE.
  - Transitions: IDLE -> CALC on accept; CALC -> DONE after N cycles; DONE -> IDLE unconditionally.
- Latency: accept at edge k -> productDone high during cycle k+N+1 -> next accept possible at edge k+N+2. Latency does not depend on operand values or mode.
- start while busy=1 (including the DONE cycle) is ignored. Operands and mode are not re-sampled.
- Arithmetic:
  - unsigned mode: product = A*B, full 2*WIDTH bits.
  - signed mode: product = sext(A)*sext(B) truncated to 2*WIDTH. This is exact, including (-2^(W-1))^2.
  - Internal sum is at least 2*WIDTH+1 bits. The implementation method (magnitude/negate or Baugh-Wooley) is free, provided the latency is unchanged.
- product holds its value from DONE until the DONE of the next operation. It does not change during CALC.
- Taint (1-bit, conservative):
  - At accept, latch d_t = multiplier_t | multiplicand_t | signed_mode_t and c_t = start_t.
  - busy_t = c_t while busy=1; 0 in IDLE.
  - At DONE: product_t <= d_t | c_t. product_t holds with product.
  - productDone_t = c_t during DONE, else 0. Operand taint never reaches productDone_t or busy_t, because latency is data-independent.
  - start_t=1 while start=0 in IDLE: no accept, but the outcome of the accept decision is tainted. Set product_t <= 1 and productDone_t pulses 1 for one cycle at the next edge (tainted "no-event"). product is unchanged.
  - Taint inputs sampled while busy have no effect.

Test Plan:
- WIDTH=8, STEP=2, unsigned, A=3, B=5, all taints 0, start pulse at edge k -> busy=1 from cycle k+1; productDone=1 only in cycle k+5; product=16'h000F; product_t=0, productDone_t=0.
- Signed extremes, WIDTH=8: A=-3 (8'hFD), B=5 -> 16'hFFF1. A=B=8'h80 -> 16'h4000. Unsigned A=B=8'hFF -> 16'hFE01. Every case has identical 5-cycle latency.
- Taint propagation: A=7, B=9, multiplier_t=1, other taints 0 -> product=63, product_t=1, productDone_t=0, busy_t=0. Repeat with start_t=1 and operand taints 0 -> product_t=1, productDone_t=1, busy_t=1 during busy.
- Busy rejection: second start with A=2, B=2 at edge k+2 -> ignored. First result (15) is delivered at k+5. busy falls at k+6. A new start at k+6 is accepted and gives 4 at k+11.
- Reset mid-CALC: rst=1 at edge k+3 -> all outputs 0 next cycle. No productDone pulse appears at k+5. A start after reset completes normally.
- Sweep: WIDTH=16 with STEP in {1,2,4,8}, 1000 random operands per config, both modes -> matches reference model. Latency is exactly WIDTH/STEP+1.

Source files
------------

// File: rtl/multiplier_taint_radix.sv
// Radix-2^STEP shift-add multiplier (signed/unsigned) with coarse 1-bit taint; latency WIDTH/STEP+1 cycles from accept to productDone.
// No backpressure: start is ignored while busy, and the product is held until the next operation completes.
module multiplier_taint_radix #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 start_t,
  input  logic                 signed_mode,
  input  logic                 signed_mode_t,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 multiplier_t,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 multiplicand_t,
  output logic                 busy,
  output logic                 busy_t,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_t,
  output logic                 productDone,
  output logic                 productDone_t
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = 2 * WIDTH + 1;

  if (((WIDTH % STEP) != 0) || (WIDTH < 4) || (STEP < 1)) begin : g_param_check
    $error("multiplier_taint_radix: WIDTH must be >= 4 and a multiple of STEP");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic             accept;
  logic             last;
  logic             noevt_nx, noevt_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [SW-1:0]    b_reg;
  logic [SW-1:0]    sum, sum_nx;
  logic [SW-1:0]    dig_ext;
  logic             sign_bit;
  logic             sm_q;
  logic             d_t, c_t;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    busy          = 1'b0;
    busy_t        = 1'b0;
    productDone   = 1'b0;
    productDone_t = noevt_q;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        busy   = 1'b1;
        busy_t = c_t;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        busy_t        = c_t;
        productDone   = 1'b1;
        productDone_t = c_t;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A tainted start that is low still taints the accept decision: flag a tainted "no-event".
  assign noevt_nx = (state == IDLE) && !start && start_t;
  assign last     = (cnt == CW'(N - 1));

  // In signed mode the top digit carries negative weight, giving sext(A) without a separate fix-up.
  assign sign_bit = sm_q && last && a_reg[STEP-1];
  assign dig_ext  = {{(2*WIDTH-STEP){sign_bit}}, sign_bit, a_reg[STEP-1:0]};
  assign sum_nx   = sum + b_reg * dig_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      noevt_q   <= 1'b0;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      sm_q      <= 1'b0;
      d_t       <= 1'b0;
      c_t       <= 1'b0;
      product   <= '0;
      product_t <= 1'b0;
    end else begin
      noevt_q <= noevt_nx;
      if (noevt_nx) product_t <= 1'b1;
      if (accept) begin
        a_reg <= multiplier;
        b_reg <= signed_mode ? {{(WIDTH+1){multiplicand[WIDTH-1]}}, multiplicand}
                             : {{(WIDTH+1){1'b0}}, multiplicand};
        sum   <= '0;
        cnt   <= '0;
        sm_q  <= signed_mode;
        d_t   <= multiplier_t | multiplicand_t | signed_mode_t;
        c_t   <= start_t;
      end
      if (state == CALC) begin
        sum   <= sum_nx;
        a_reg <= a_reg >> STEP;
        b_reg <= b_reg << STEP;
        cnt   <= cnt + CW'(1);
        if (last) begin
          product   <= sum_nx[2*WIDTH-1:0];
          product_t <= d_t | c_t;
        end
      end
    end
  end

endmodule
